// File: rtl/pipe_ctl.sv
// pipe_ctl: valid/payload registers of an in-order pipeline with back-pressure, bubbles, flushes and perf counters
module pipe_ctl #(
  parameter int STAGES = 5,
  parameter int W = 64,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_data,
  output logic                  in_ready,
  input  logic [STAGES-1:0]     stage_hold,
  input  logic [STAGES-1:0]     flush_req,
  output logic [STAGES-1:0]     stage_valid,
  output logic [STAGES*W-1:0]   stage_data,
  output logic [STAGES-1:0]     stage_fire,
  output logic                  out_valid,
  output logic [W-1:0]          out_data,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  logic [STAGES-1:0] validQ;
  logic [W-1:0]      dataQ [STAGES];
  logic [STAGES-1:0] accept;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] srcFire;
  logic [STAGES-1:0] srcKill;
  logic [W-1:0]      srcData [STAGES];

  // Ready chain oldest to youngest; kill marks stages below the oldest valid flushing stage.
  always_comb begin : readyChain
    logic acc;
    logic killAcc;
    acc = 1'b1;
    killAcc = 1'b0;
    stage_fire = '0;
    accept = '0;
    kill = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      stage_fire[i] = validQ[i] & ~stage_hold[i] & acc;
      acc = ~validQ[i] | stage_fire[i];
      accept[i] = acc;
      kill[i] = killAcc;
      killAcc = killAcc | (flush_req[i] & validQ[i]);
    end
  end

  // What each stage would receive: fetch for stage 0, the next-younger stage otherwise.
  always_comb begin
    srcFire[0] = in_valid & in_ready;
    srcKill[0] = |flush_req;
    srcData[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      srcFire[i] = stage_fire[i-1];
      srcKill[i] = kill[i-1];
      srcData[i] = dataQ[i-1];
    end
  end

  // Stage registers: load on accept, hold otherwise, flush clears younger stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      validQ <= '0;
      for (int i = 0; i < STAGES; i++) dataQ[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        validQ[i] <= ~kill[i] & (accept[i] ? srcFire[i] & ~srcKill[i] : validQ[i]);
        if (accept[i] && srcFire[i]) dataQ[i] <= srcData[i];
      end
    end
  end

  // Performance counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      retire_cnt <= retire_cnt + CNT_W'(out_valid);
      stall_cnt <= stall_cnt + CNT_W'(in_valid & ~in_ready);
      flush_cnt <= flush_cnt + CNT_W'(|flush_req);
    end
  end

  // Flatten payloads for the stage datapaths.
  always_comb begin
    stage_data = '0;
    for (int i = 0; i < STAGES; i++) stage_data[i*W +: W] = dataQ[i];
  end

  assign in_ready = accept[0];
  assign stage_valid = validQ;
  assign out_valid = stage_fire[STAGES-1];
  assign out_data = dataQ[STAGES-1];
endmodule

// File: tb/tb_pipe_ctl.sv
// tb_pipe_ctl: directed scenarios plus random traffic checked against a slot-level pipeline model
module tb_pipe_ctl;
  localparam int S = 5;
  localparam int W = 8;
  localparam int CW = 4;

  logic clk = 0;
  logic reset = 1;
  logic inValid = 0;
  logic [W-1:0] inData = '0;
  logic inReady;
  logic [S-1:0] stageHold = '0;
  logic [S-1:0] flushReq = '0;
  logic [S-1:0] stageValid;
  logic [S*W-1:0] stageData;
  logic [S-1:0] stageFire;
  logic outValid;
  logic [W-1:0] outData;
  logic [CW-1:0] retireCnt, stallCnt, flushCnt;

  int checks = 0;
  int errors = 0;

  bit mv [S];
  logic [W-1:0] md [S];
  logic [CW-1:0] mRet = '0, mStall = '0, mFlush = '0;

  pipe_ctl #(.STAGES(S), .W(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_data(inData), .in_ready(inReady),
    .stage_hold(stageHold), .flush_req(flushReq), .stage_valid(stageValid),
    .stage_data(stageData), .stage_fire(stageFire), .out_valid(outValid), .out_data(outData),
    .retire_cnt(retireCnt), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare DUT against the model, then advance the model.
  task automatic step(input logic rst, input logic iv, input logic [W-1:0] id, input logic [S-1:0] h, input logic [S-1:0] f);
    bit blk [S];
    bit fire [S];
    bit nv [S];
    logic [W-1:0] nd [S];
    logic [S-1:0] expValid, expFire;
    bit down, ready, anyF, src, srcOk;
    logic [W-1:0] sd;
    int k;
    @(negedge clk);
    reset = rst; inValid = iv; inData = id; stageHold = h; flushReq = f;
    #1;
    down = 0;
    for (int i = S - 1; i >= 0; i--) begin
      blk[i] = mv[i] && (h[i] || down);
      fire[i] = mv[i] && !blk[i];
      down = blk[i];
    end
    ready = !blk[0];
    anyF = |f;
    k = -1;
    for (int i = 0; i < S; i++) if (f[i] && mv[i]) k = i;
    if (!rst) begin
      expValid = '0; expFire = '0;
      for (int i = 0; i < S; i++) begin
        expValid[i] = mv[i];
        expFire[i] = fire[i];
      end
      checkEq("stageValid", stageValid, expValid);
      for (int i = 0; i < S; i++) if (mv[i]) checkEq("stageData", stageData[i*W +: W], md[i]);
      checkEq("retireCnt", retireCnt, mRet);
      checkEq("stallCnt", stallCnt, mStall);
      checkEq("flushCnt", flushCnt, mFlush);
      checkEq("inReady", inReady, ready);
      checkEq("stageFire", stageFire, expFire);
      checkEq("outValid", outValid, fire[S-1]);
      if (fire[S-1]) checkEq("outData", outData, md[S-1]);
    end
    if (rst) begin
      for (int i = 0; i < S; i++) begin mv[i] = 0; md[i] = '0; end
      mRet = '0; mStall = '0; mFlush = '0;
    end else begin
      for (int i = S - 1; i >= 0; i--) begin
        nv[i] = mv[i]; nd[i] = md[i];
        if (!blk[i]) begin
          if (i == 0) begin src = iv && ready; sd = id; srcOk = src && !anyF; end
          else begin src = fire[i-1]; sd = md[i-1]; srcOk = src && !(k >= i); end
          nv[i] = srcOk;
          if (src) nd[i] = sd;
        end
        if (i < k) nv[i] = 0;
      end
      for (int i = 0; i < S; i++) begin mv[i] = nv[i]; md[i] = nd[i]; end
      mRet += CW'(fire[S-1]);
      mStall += CW'(iv && !ready);
      mFlush += CW'(anyF);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0);
  endtask

  task automatic fill(input logic [W-1:0] base);
    for (int i = 0; i < S; i++) step(0, 1, base + W'(S - 1 - i), '0, '0);
  endtask

  initial begin
    logic [S-1:0] h, f;
    step(1, 0, '0, '0, '0);
    step(1, 0, '0, '0, '0);
    // reset and stream
    for (int i = 1; i <= 10; i++) step(0, 1, W'(i), '0, '0);
    idle(6);
    @(posedge clk); #1;
    checkEq("streamRetire", retireCnt, 4'd10);
    checkEq("streamStall", stallCnt, 4'd0);
    // multi-cycle hold on a full pipeline
    fill(8'h20);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h30 + W'(i), 5'b01000, '0);
    idle(8);
    // fill behind a holding stage
    step(0, 1, 8'h40, '0, '0);
    idle(3);
    for (int i = 0; i < 6; i++) step(0, 1, 8'h41 + W'(i), 5'b01000, '0);
    idle(10);
    // flush with simultaneous input
    fill(8'h10);
    step(0, 1, 8'hEE, '0, 5'b00100);
    @(posedge clk); #1;
    checkEq("flushValid", stageValid, 5'b11000);
    idle(6);
    // flush during hold
    fill(8'h50);
    step(0, 1, 8'hEF, 5'b10000, 5'b00100);
    @(posedge clk); #1;
    checkEq("flushHoldValid", stageValid, 5'b11100);
    idle(6);
    // counter wrap
    step(1, 0, '0, '0, '0);
    for (int i = 0; i < 17; i++) step(0, 1, W'(i + 100), '0, '0);
    idle(6);
    @(posedge clk); #1;
    checkEq("retireWrap", retireCnt, 4'd1);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      h = '0;
      for (int i = 0; i < S; i++) h[i] = ($urandom_range(0, 99) < 12);
      f = ($urandom_range(0, 19) == 0) ? S'($urandom_range(1, (1 << S) - 1)) : '0;
      step(0, $urandom_range(0, 3) != 0, W'($urandom), h, f);
    end
    // reset mid-flight with a full pipeline
    fill(8'h60);
    step(1, 0, '0, 5'b10000, 5'b00100);
    @(negedge clk); #1;
    checkEq("rstValid", stageValid, '0);
    checkEq("rstData", stageData, '0);
    checkEq("rstOutValid", outValid, 1'b0);
    checkEq("rstOutData", outData, '0);
    checkEq("rstReady", inReady, 1'b1);
    checkEq("rstRetire", retireCnt, '0);
    checkEq("rstStall", stallCnt, '0);
    checkEq("rstFlush", flushCnt, '0);
    for (int i = 1; i <= 8; i++) step(0, 1, W'(i), '0, '0);
    idle(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctl.md
# pipe_ctl

Parametrised pipeline-control block for the MIPS core: it holds the valid bits and payload registers of an N-stage in-order pipeline, propagates back-pressure from any stalled stage, inserts bubbles and squashes wrong-path instructions. It replaces the open-coded per-stage stall/bubble logic in the core top level. It adds multi-cycle stage holds for slow ibus/dbus responses, branch flushes, and performance counters. It sits between fetch and the stage datapaths; each stage reads its payload from `stage_data` and reports holds and flushes back.

## Interface
- `STAGES`, 5: number of pipeline register stages, 2..8. Stage 0 is the youngest, fed by `in_*`; stage STAGES-1 is the oldest and retires to `out_*`.
- `W`, 64: payload width per stage (pc, control, register indices, operands, packed by the user).
- `CNT_W`, 32: width of each performance counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fetch presents an instruction.
- `in_data`  in  W  payload for stage 0.
- `in_ready`  out  1  stage 0 accepts this cycle (combinational).
- `stage_hold`  in  STAGES  bit i: stage i cannot complete this cycle (load-use, dbus/ibus not data_ok).
- `flush_req`  in  STAGES  bit i: squash every stage younger than i, plus the incoming instruction.
- `stage_valid`  out  STAGES  registered valid bit per stage.
- `stage_data`  out  STAGES*W  registered payloads; stage i occupies bits [i*W +: W].
- `stage_fire`  out  STAGES  bit i: stage i advances this cycle (combinational).
- `out_valid`  out  1  equals `stage_fire[STAGES-1]`; the oldest instruction retires.
- `out_data`  out  W  equals stage STAGES-1 payload.
- `retire_cnt`, `stall_cnt`, `flush_cnt`  out  CNT_W each  performance counters.

## Operation
Per stage i, with `v_i` as the valid bit, `move_i` as `stage_fire[i]` and `acc_i` as "stage i can accept":
- `acc_STAGES` = 1, since retirement is never back-pressured.
- `move_i` = v_i & !stage_hold[i] & acc_(i+1).
- `acc_i` = !v_i | move_i.
- `in_ready` = acc_0.
- Stage input fire is `in_valid & in_ready`.
- The ready chain is combinational from oldest to youngest. It must contain no loop through `flush_req`.

Register update, when `acc_i` is set:
- v_i <= move_(i-1). For stage 0, the source is the input fire.
- The payload loads only when the source moves. On a bubble the payload is left unchanged.

Register update, when `acc_i` is clear: v_i and the payload are held.

Hold behaviour:
- A hold on stage i stalls stages 0..i wherever they are occupied.
- Stage i+1 receives a bubble.
- Empty stages behind the hold still fill.

Flush:
- Let k be the highest set bit of `flush_req`.
- Next cycle, v_0..v_(k-1) <= 0 and the incoming instruction is dropped.
- `in_ready` is still reported, so fetch redirects without a handshake.
- Stage k itself is unaffected: it moves or holds as normal.
- Whatever stage k-1 would have passed into stage k becomes a bubble.
- Flush overrides any move or hold in the killed stages.
- `stage_fire` for a killed stage may still be 1. Consumers must not commit side effects from stages younger than the flushing stage.
- Lower flush bits set in the same cycle are subsumed by k.

Counters, all wrapping modulo 2^CNT_W:
- `retire_cnt`: +1 per cycle with `out_valid`.
- `stall_cnt`: +1 per cycle with `in_valid & !in_ready`.
- `flush_cnt`: +1 per cycle with `|flush_req`.

## Timing
- Reset: every v_i, payload and counter is 0. As a result `stage_valid`=0, `stage_data`=0, `out_valid`=0, `out_data`=0 and `in_ready`=1 during and after reset.
- Reset asserted mid-operation discards all in-flight entries at the next edge, overriding hold and flush.
- Latency: with no holds, an instruction accepted at cycle t is in stage i at t+1+i and retires (`out_valid`) in cycle t+STAGES.
- Throughput: 1 instruction per cycle with no holds.
- A hold lasting H cycles on a full pipeline costs exactly H cycles of throughput and creates one bubble per hold cycle downstream.
- `flush_req` in cycle t is visible as cleared `stage_valid` at t+1. An instruction presented at t+1 is accepted normally.
- `stage_hold` and `flush_req` bits for invalid stages are ignored, except that a flush always drops the incoming instruction.

## Test plan
Bench configuration: STAGES=5, W=8.
- **Reset and stream:** after reset, stream payloads 0x01..0x0A back-to-back → `out_valid` from cycle 5, outputs 0x01..0x0A in order, `retire_cnt`=10, `stall_cnt`=0.
- **Multi-cycle hold:** full pipeline, `stage_hold[3]` for 3 cycles → stages 0..3 frozen, 3 bubbles retire, `in_ready`=0 for 3 cycles, `stall_cnt`=3, no payload lost or duplicated.
- **Fill behind hold:** stages 0..2 empty, stage 3 holding → stages 0..2 fill, then `in_ready` falls.
- **Flush:** full pipeline, payloads 0x10..0x14, `flush_req`=5'b00100 with a simultaneous `in_valid` → stages 0,1 and the input are squashed, stage 2's payload proceeds, `flush_cnt`=1. Next retired sequence is 0x14,0x13,0x12 then bubbles.
- **Flush during hold:** hold on stage 4 and `flush_req[2]` in the same cycle → stages 0,1 cleared, stages 2..4 held.
- **Counter wrap and reset mid-flight:** CNT_W=4, retire 17 instructions → `retire_cnt`=1. Assert `reset` with 5 valid stages → all outputs 0 next cycle.
